// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
//
// Requesters are served round-robin through valid/ready handshakes. Each port has a one-entry
// registered response buffer and a saturating grant counter.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   reqN_valid/ready/a/b/ctrl       request channel of port N (N = 0, 1)
//   rspN_valid/ready/result/zero    response channel of port N
//   gnt0_cnt, gnt1_cnt              saturating grant counters
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
);

  logic             rsp0_valid_q, rsp1_valid_q;
  logic [WIDTH-1:0] rsp0_result_q, rsp1_result_q;
  logic             rsp0_zero_q, rsp1_zero_q;
  logic [CNT_W-1:0] gnt0_cnt_q, gnt1_cnt_q;
  logic             ptr_q;

  logic             elig0, elig1, gnt0, gnt1;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [2:0]       alu_ctrl;
  logic             alu_zero;

  // A full slot that is being drained this cycle can be refilled in the same cycle.
  // Eligibility is masked during reset so no request is accepted while it is asserted.
  always_comb begin
    elig0 = !reset && req0_valid && (!rsp0_valid_q || rsp0_ready);
    elig1 = !reset && req1_valid && (!rsp1_valid_q || rsp1_ready);
    gnt0  = elig0 && (!elig1 || !ptr_q);
    gnt1  = elig1 && (!elig0 ||  ptr_q);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Single shared ALU; operands come from whichever port holds the grant.
  always_comb begin
    alu_a    = gnt1 ? req1_a    : req0_a;
    alu_b    = gnt1 ? req1_b    : req0_b;
    alu_ctrl = gnt1 ? req1_ctrl : req0_ctrl;
    alu_y    = '0;
    unique case (alu_ctrl)
      3'b010:  alu_y = alu_a + alu_b;
      3'b110:  alu_y = alu_a - alu_b;
      3'b000:  alu_y = alu_a & alu_b;
      3'b001:  alu_y = alu_a | alu_b;
      3'b111:  alu_y = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
      default: alu_y = '0;
    endcase
    alu_zero = (alu_y == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_zero_q   <= 1'b0;
      gnt0_cnt_q    <= '0;
      gnt1_cnt_q    <= '0;
      ptr_q         <= 1'b0;
    end else begin
      if (gnt0) begin
        rsp0_valid_q  <= 1'b1;
        rsp0_result_q <= alu_y;
        rsp0_zero_q   <= alu_zero;
        ptr_q         <= 1'b1;
        if (gnt0_cnt_q != '1) gnt0_cnt_q <= gnt0_cnt_q + 1'b1;
      end else if (rsp0_ready) begin
        rsp0_valid_q <= 1'b0;
      end

      if (gnt1) begin
        rsp1_valid_q  <= 1'b1;
        rsp1_result_q <= alu_y;
        rsp1_zero_q   <= alu_zero;
        ptr_q         <= 1'b0;
        if (gnt1_cnt_q != '1) gnt1_cnt_q <= gnt1_cnt_q + 1'b1;
      end else if (rsp1_ready) begin
        rsp1_valid_q <= 1'b0;
      end
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_zero   = rsp1_zero_q;
  assign gnt0_cnt    = gnt0_cnt_q;
  assign gnt1_cnt    = gnt1_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: opcode vector table on port 0, then hand-written sequences
// for contention, backpressure, reset mid-operation and counter saturation (CNT_W = 4).
module tb_alu_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [WIDTH-1:0] req0_a, req0_b, rsp0_result, req1_a, req1_b, rsp1_result;
  logic [2:0]       req0_ctrl, req1_ctrl;
  logic [CNT_W-1:0] gnt0_cnt, gnt1_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_result(rsp0_result),
    .rsp0_zero  (rsp0_zero),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_result(rsp1_result),
    .rsp1_zero  (rsp1_zero),
    .gnt0_cnt   (gnt0_cnt),
    .gnt1_cnt   (gnt1_cnt)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rsp0_valid"}, 32'(rsp0_valid), 32'd0);
    chk({tag, " rsp1_valid"}, 32'(rsp1_valid), 32'd0);
    chk({tag, " rsp0_result"}, rsp0_result, 32'd0);
    chk({tag, " rsp1_result"}, rsp1_result, 32'd0);
    chk({tag, " rsp0_zero"}, 32'(rsp0_zero), 32'd0);
    chk({tag, " rsp1_zero"}, 32'(rsp1_zero), 32'd0);
    chk({tag, " gnt0_cnt"}, 32'(gnt0_cnt), 32'd0);
    chk({tag, " gnt1_cnt"}, 32'(gnt1_cnt), 32'd0);
    chk({tag, " req0_ready"}, 32'(req0_ready), 32'd0);
    chk({tag, " req1_ready"}, 32'(req1_ready), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{32'd5,         32'd3,          3'b010, 32'd8,          1'b0};
    vecs[1] = '{32'd7,         32'd7,          3'b110, 32'd0,          1'b1};
    vecs[2] = '{32'h0000_00F0, 32'h0000_000F,  3'b001, 32'h0000_00FF,  1'b0};
    vecs[3] = '{32'd3,         32'd9,          3'b111, 32'd1,          1'b0};
    vecs[4] = '{32'd9,         32'd3,          3'b111, 32'd0,          1'b1};
    vecs[5] = '{32'd12,        32'd34,         3'b011, 32'd0,          1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 32'd1,          3'b010, 32'd0,          1'b1};
    vecs[7] = '{32'h0000_FF00, 32'h0000_0FF0,  3'b000, 32'h0000_0F00,  1'b0};
    vecs[8] = '{32'd3,         32'd5,          3'b110, 32'hFFFF_FFFE,  1'b0};
    vecs[9] = '{32'hFFFF_FFFF, 32'd0,          3'b111, 32'd0,          1'b1};

    // Requests held valid during reset to confirm ready stays low.
    reset      = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 3'b010;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_ctrl = 3'b010;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #2;
    tick();
    chk_all_zero("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    #1;

    // Opcode table, back-to-back on port 0.
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1;
      req0_a     = vecs[i].a;
      req0_b     = vecs[i].b;
      req0_ctrl  = vecs[i].ctrl;
      #1;
      chk($sformatf("vec%0d req0_ready", i), 32'(req0_ready), 32'd1);
      tick();
      chk($sformatf("vec%0d rsp0_valid", i), 32'(rsp0_valid), 32'd1);
      chk($sformatf("vec%0d result", i), rsp0_result, vecs[i].res);
      chk($sformatf("vec%0d zero", i), 32'(rsp0_zero), 32'(vecs[i].zero));
      if (i == 0) chk("single gnt0_cnt", 32'(gnt0_cnt), 32'd1);
    end
    req0_valid = 1'b0;
    chk("table gnt0_cnt", 32'(gnt0_cnt), 32'd10);
    tick();
    chk("drain rsp0_valid", 32'(rsp0_valid), 32'd0);

    // Contention: grants must alternate 0,1,0,1.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd7;  req0_b = 32'd7;  req0_ctrl = 3'b110;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = 3'b001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d req0_ready", i), 32'(req0_ready), 32'((i % 2) == 0));
      chk($sformatf("cont%0d req1_ready", i), 32'(req1_ready), 32'((i % 2) == 1));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont rsp0_result", rsp0_result, 32'd0);
    chk("cont rsp0_zero", 32'(rsp0_zero), 32'd1);
    chk("cont rsp1_result", rsp1_result, 32'hFF);
    chk("cont rsp1_zero", 32'(rsp1_zero), 32'd0);
    chk("cont gnt0_cnt", 32'(gnt0_cnt), 32'd2);
    chk("cont gnt1_cnt", 32'(gnt1_cnt), 32'd2);

    // Backpressure on port 0.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 3'b010;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_ctrl = 3'b010;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("bp first req0_ready", 32'(req0_ready), 32'd1);
    chk("bp first req1_ready", 32'(req1_ready), 32'd0);
    tick();
    chk("bp first result", rsp0_result, 32'd8);
    req0_a = 32'd2; req0_b = 32'd2;
    rsp0_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d req0_ready", i), 32'(req0_ready), 32'd0);
      chk($sformatf("bp%0d req1_ready", i), 32'(req1_ready), 32'd1);
      tick();
      chk($sformatf("bp%0d rsp0_valid", i), 32'(rsp0_valid), 32'd1);
      chk($sformatf("bp%0d rsp0_result", i), rsp0_result, 32'd8);
      chk($sformatf("bp%0d rsp1_result", i), rsp1_result, 32'd2);
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp release req0_ready", 32'(req0_ready), 32'd1);
    chk("bp release req1_ready", 32'(req1_ready), 32'd0);
    tick();
    chk("bp release rsp0_result", rsp0_result, 32'd4);
    chk("bp gnt1_cnt", 32'(gnt1_cnt), 32'd3);

    // Fill both slots, leaving ptr at 1, then reset between edges.
    req0_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; rsp0_ready = 1'b1;
    tick();
    req0_valid = 1'b0; rsp0_ready = 1'b0;
    chk("pre-reset rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("pre-reset rsp1_valid", 32'(rsp1_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    #3;
    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("post-reset req0_ready", 32'(req0_ready), 32'd1);
    chk("post-reset req1_ready", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Counter saturation with a 4-bit counter.
    do_reset();
    req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) chk("sat gnt1_cnt at 15", 32'(gnt1_cnt), 32'd15);
    end
    req1_valid = 1'b0;
    chk("sat gnt1_cnt", 32'(gnt1_cnt), 32'd15);
    chk("sat gnt0_cnt", 32'(gnt0_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters (port 0, port 1), e.g. the main datapath and an address/branch-compare unit.
- Round-robin arbitration with valid/ready handshakes. Each port gets a one-entry registered response buffer.
- Per-port saturating grant counters support performance observation.
- Contains exactly one ALU instance; no other arithmetic logic.

Parameters:
- WIDTH, 32, operand/result width; fixed to 32 to match the ALU; other values unsupported.
- CNT_W, 16, width of each grant counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  port 0 request valid
- req0_ready  output  1  port 0 request accepted this cycle
- req0_a  input  WIDTH  port 0 operand A
- req0_b  input  WIDTH  port 0 operand B
- req0_ctrl  input  3  port 0 ALU control code
- rsp0_valid  output  1  port 0 response valid
- rsp0_ready  input  1  port 0 consumer accepts response
- rsp0_result  output  WIDTH  port 0 result
- rsp0_zero  output  1  port 0 zero flag
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl, rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero: same as port 0, for port 1
- gnt0_cnt  output  CNT_W  grants issued to port 0, saturating
- gnt1_cnt  output  CNT_W  grants issued to port 1, saturating

Behaviour:
- ALU function (3-bit control code):
  - 010 = A+B
  - 110 = A-B (mod 2^32)
  - 000 = A&B
  - 001 = A|B
  - 111 = 1 if A<B unsigned, else 0
  - any other code gives result 0
  - zero = (result == 0)
- Slot free: slot i is free when rsp_i_valid == 0, or when rsp_i_valid && rsp_i_ready in the same cycle (drain and refill allowed).
- Eligibility: port i is eligible when req_i_valid && slot i is free.
- Grant rule (combinational, at most one grant per cycle):
  - Only one port eligible: grant it.
  - Both eligible: grant the port selected by priority pointer ptr (0 or 1).
  - Neither eligible: no grant.
- req_i_ready = grant_i. Asserted only when req_i_valid is high; never depends on the other port's ready.
- On a granted cycle, at the clock edge:
  - ALU output is captured into slot i; rsp_i_valid <= 1.
  - ptr <= ~i.
  - gnt_i_cnt increments, saturating at all-ones.
- ptr is unchanged on cycles with no grant.
- Latency: request accepted in cycle N gives response visible in cycle N+1.
  - Throughput is 1 op/cycle total.
  - A single port sustains 1 op/cycle while its consumer holds rsp_ready high.
- Response drained without refill (rsp_i_valid && rsp_i_ready, no grant_i): rsp_i_valid <= 0. Result and zero hold their last value; their value is don't-care while rsp_i_valid is 0.
- Response stability: while rsp_i_valid && !rsp_i_ready, rsp_i_result and rsp_i_zero are stable.
- Requester contract: must hold operands and ctrl stable while req_valid is high and ready is low. Arbiter behaviour is undefined otherwise.
- Backpressure interaction: if port i's slot is full and not draining, port i is ineligible. The other port is then granted regardless of ptr, and ptr still toggles to ~(granted port).
- Reset (asynchronous, any cycle, including mid-handshake):
  - Clears rsp0_valid, rsp1_valid, rsp results and zero flags.
  - Sets ptr = 0 and both counters = 0.
  - In-flight requests are discarded.
  - req_ready outputs are 0 while reset is asserted.
- Reset values: all outputs 0.

Test Plan:
- Single op: after reset, port 0 requests A=5, B=3, ctrl=010 with rsp0_ready=1 -> req0_ready=1 in cycle 0; rsp0_valid=1, result=8, zero=0 in cycle 1; gnt0_cnt=1.
- Contention: both ports valid for 4 cycles, port 0 sub 7-7 and port 1 or 0xF0|0x0F, consumers ready -> grants alternate 0,1,0,1; port 0 result=0 with zero=1; port 1 result=0xFF; both counters=2.
- Backpressure: port 0 consumer holds rsp0_ready=0 after its first response; both keep requesting -> port 1 is granted every cycle; rsp0_result stays stable; when rsp0_ready rises, port 0 is granted in that same cycle.
- Opcodes: slt 3<9 gives 1; slt 9<3 gives 0 with zero=1; ctrl=011 gives 0 with zero=1; 0xFFFFFFFF+1 wraps to 0 with zero=1.
- Saturation: with CNT_W=4, run 20 back-to-back port 1 grants -> gnt1_cnt stops at 15; gnt0_cnt=0.
- Reset mid-operation: assert reset asynchronously between clock edges while both rsp_valid=1 -> all outputs go to 0 immediately; after release, the first contended grant goes to port 0.
